multi_event_sync: RTL and testbench

//   Parametrised N-channel synchroniser for asynchronous inputs (buttons, strobes, off-chip flags).

---
 rtl/multi_event_sync_if.sv | 28 ++
 rtl/multi_event_sync.sv | 87 ++++++++
 tb/tb_multi_event_sync.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_event_sync_if.sv
// Channel bundle for multi_event_sync: raw inputs and controls in, filtered level/pulse/pending/count out.
// The master side drives the inputs; the slave side is the synchroniser itself.
interface multi_event_sync_if #(
  parameter int N     = 8,
  parameter int CNT_W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic               ena;
  logic [N-1:0]       async_in;
  logic [1:0]         mode;
  logic [N-1:0]       clr;
  logic [SW-1:0]      cnt_sel;
  logic [N-1:0]       level_out;
  logic [N-1:0]       pulse_out;
  logic [N-1:0]       pending;
  logic [CNT_W-1:0]   cnt_out;

  modport master (
    output ena, async_in, mode, clr, cnt_sel,
    input  level_out, pulse_out, pending, cnt_out
  );

  modport slave (
    input  ena, async_in, mode, clr, cnt_sel,
    output level_out, pulse_out, pending, cnt_out
  );
endinterface

// File: rtl/multi_event_sync.sv
// N-channel synchroniser + stability filter + edge detector with pending flags and saturating counters.
// Level and pulse change STAGES+FILTER edges after an input change; ena low freezes everything but the sync chain and clr.
module multi_event_sync #(
  parameter int N      = 8,
  parameter int STAGES = 2,
  parameter int FILTER = 4,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst,
  multi_event_sync_if.slave bus
);
  localparam int               FW     = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [FW-1:0]    F_LAST = FW'(FILTER - 1);
  localparam logic [CNT_W-1:0] C_MAX  = '1;

  logic [STAGES-1:0][N-1:0] sync_r;
  logic [N-1:0]             sync_q;
  logic [N-1:0]             level_q;
  logic [N-1:0]             pulse_q;
  logic [N-1:0]             pend_q;
  logic [N-1:0]             flip;
  logic [N-1:0]             ev;
  logic [N-1:0][FW-1:0]     fcnt;
  logic [N-1:0][CNT_W-1:0]  cnt;

  assign sync_q = sync_r[STAGES-1];

  // The synchroniser chain is never gated so the filter always sees fresh samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_r <= '0;
    else     sync_r <= {sync_r[STAGES-2:0], bus.async_in};
  end

  // flip: this edge completes FILTER consecutive mismatching samples.
  always_comb begin
    flip = '0;
    for (int i = 0; i < N; i++)
      flip[i] = bus.ena && (sync_q[i] != level_q[i]) && (fcnt[i] == F_LAST);
  end

  always_comb begin
    ev = '0;
    case (bus.mode)
      2'b00:   ev = flip & sync_q;
      2'b01:   ev = flip & ~sync_q;
      2'b10:   ev = flip;
      default: ev = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt    <= '0;
      level_q <= '0;
      pulse_q <= '0;
      pend_q  <= '0;
      cnt     <= '0;
    end else begin
      pulse_q <= ev;
      for (int i = 0; i < N; i++) begin
        if (bus.ena) begin
          if (sync_q[i] == level_q[i] || flip[i]) fcnt[i] <= '0;
          else                                     fcnt[i] <= fcnt[i] + FW'(1);
        end
        if (flip[i]) level_q[i] <= sync_q[i];
        // A clear in the same cycle as an event keeps that event.
        if (bus.clr[i]) begin
          pend_q[i] <= ev[i];
          cnt[i]    <= CNT_W'(ev[i]);
        end else if (ev[i]) begin
          pend_q[i] <= 1'b1;
          if (cnt[i] != C_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.level_out = level_q;
  assign bus.pulse_out = pulse_q;
  assign bus.pending   = pend_q;

  always_comb begin
    bus.cnt_out = '0;
    if (int'(bus.cnt_sel) < N) bus.cnt_out = cnt[bus.cnt_sel];
  end
endmodule

// File: tb/tb_multi_event_sync.sv
// Bench for multi_event_sync: directed scenarios plus randomized traffic against a behavioural model.
module tb_multi_event_sync;
  localparam int N      = 8;
  localparam int STAGES = 2;
  localparam int FILTER = 4;
  localparam int CNT_W  = 8;
  localparam int NB     = 6;
  localparam int CWB    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_event_sync_if #(.N(N),  .CNT_W(CNT_W)) ifa ();
  multi_event_sync_if #(.N(NB), .CNT_W(CWB))   ifb ();

  multi_event_sync #(.N(N), .STAGES(STAGES), .FILTER(FILTER), .CNT_W(CNT_W)) ua (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  multi_event_sync #(.N(NB), .STAGES(STAGES), .FILTER(FILTER), .CNT_W(CWB)) ub (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  int checks   = 0;
  int failures = 0;

  // Behavioural model of DUT A: input delay line, run lengths of disagreement, event bookkeeping.
  logic [N-1:0] m_dly [STAGES];
  logic [N-1:0] m_level, m_pulse, m_pend;
  int           m_run [N];
  int           m_cnt [N];

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) m_dly[k] = '0;
    m_level = '0; m_pulse = '0; m_pend = '0;
    for (int i = 0; i < N; i++) begin m_run[i] = 0; m_cnt[i] = 0; end
  endtask

  task automatic model_step();
    logic [N-1:0] s;
    logic ev;
    if (rst) begin model_reset(); return; end
    s = m_dly[STAGES-1];
    for (int i = 0; i < N; i++) begin
      ev = 1'b0;
      if (ifa.ena) begin
        if (s[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == FILTER) begin
            m_level[i] = s[i];
            m_run[i] = 0;
            ev = (ifa.mode == 2'd0) ? s[i] : (ifa.mode == 2'd1) ? !s[i] : (ifa.mode == 2'd2);
          end
        end else m_run[i] = 0;
      end
      m_pulse[i] = ev;
      if (ifa.clr[i]) begin
        m_pend[i] = ev;
        m_cnt[i]  = ev ? 1 : 0;
      end else if (ev) begin
        m_pend[i] = 1'b1;
        if (m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i] = m_cnt[i] + 1;
      end
    end
    for (int k = STAGES-1; k > 0; k--) m_dly[k] = m_dly[k-1];
    m_dly[0] = ifa.async_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.ena = 1'b1; ifa.async_in = '0; ifa.mode = 2'd0; ifa.clr = '0; ifa.cnt_sel = '0;
    ifb.ena = 1'b1; ifb.async_in = '0; ifb.mode = 2'd0; ifb.clr = '0; ifb.cnt_sel = '0;
    model_reset();
    #1;
    checks++; if (ifa.level_out !== '0) begin failures++; $display("FAIL reset_level got=%h exp=00", ifa.level_out); end
    checks++; if (ifa.pulse_out !== '0) begin failures++; $display("FAIL reset_pulse got=%h exp=00", ifa.pulse_out); end
    checks++; if (ifa.pending !== '0)   begin failures++; $display("FAIL reset_pending got=%h exp=00", ifa.pending); end
    checks++; if (ifa.cnt_out !== '0)   begin failures++; $display("FAIL reset_cnt got=%h exp=00", ifa.cnt_out); end
    checks++; if (ifb.cnt_out !== '0)   begin failures++; $display("FAIL reset_cnt_b got=%h exp=0", ifb.cnt_out); end
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_rise();
    ifa.mode = 2'd0; ifa.cnt_sel = 3'd3;
    ifa.async_in[3] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        checks++; if (ifa.level_out[3] !== 1'b0) begin failures++; $display("FAIL rise_early got=%b exp=0", ifa.level_out[3]); end
      end
      if (e == 6) begin
        checks++; if (ifa.level_out[3] !== 1'b1) begin failures++; $display("FAIL rise_level got=%b exp=1", ifa.level_out[3]); end
        checks++; if (ifa.pulse_out !== 8'h08)   begin failures++; $display("FAIL rise_pulse got=%h exp=08", ifa.pulse_out); end
      end
      if (e == 7) begin
        checks++; if (ifa.pulse_out[3] !== 1'b0) begin failures++; $display("FAIL rise_pulse_end got=%b exp=0", ifa.pulse_out[3]); end
        checks++; if (ifa.pending[3] !== 1'b1)   begin failures++; $display("FAIL rise_pending got=%b exp=1", ifa.pending[3]); end
        checks++; if (ifa.cnt_out !== 8'd1)      begin failures++; $display("FAIL rise_cnt got=%0d exp=1", ifa.cnt_out); end
      end
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    ifa.async_in[0] = 1'b1;
    repeat (3) tick();
    ifa.async_in[0] = 1'b0;
    repeat (10) begin
      tick();
      if (ifa.level_out[0] !== 1'b0 || ifa.pulse_out[0] !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL glitch_level cycles_changed=%0d exp=0", bad); end
    checks++; if (ifa.pending[0] !== 1'b0) begin failures++; $display("FAIL glitch_pending got=%b exp=0", ifa.pending[0]); end
  endtask

  task automatic test_modes();
    logic [1:0] modes [3] = '{2'd2, 2'd1, 2'd3};
    int         exp_p [3] = '{2, 1, 0};
    int         pulses;
    ifa.cnt_sel = 3'd5;
    for (int m = 0; m < 3; m++) begin
      ifa.clr[5] = 1'b1; tick(); ifa.clr[5] = 1'b0;
      ifa.mode = modes[m];
      pulses = 0;
      ifa.async_in[5] = 1'b1;
      repeat (10) begin tick(); if (ifa.pulse_out[5] === 1'b1) pulses++; end
      checks++; if (ifa.level_out[5] !== 1'b1) begin failures++; $display("FAIL mode%0d_level got=%b exp=1", modes[m], ifa.level_out[5]); end
      ifa.async_in[5] = 1'b0;
      repeat (10) begin tick(); if (ifa.pulse_out[5] === 1'b1) pulses++; end
      checks++; if (pulses != exp_p[m]) begin failures++; $display("FAIL mode%0d_pulses got=%0d exp=%0d", modes[m], pulses, exp_p[m]); end
      checks++; if (int'(ifa.cnt_out) != exp_p[m]) begin failures++; $display("FAIL mode%0d_cnt got=%0d exp=%0d", modes[m], ifa.cnt_out, exp_p[m]); end
    end
    ifa.mode = 2'd0;
  endtask

  task automatic test_saturate();
    ifb.mode = 2'd0; ifb.cnt_sel = 3'd1;
    repeat (5) begin
      ifb.async_in[1] = 1'b1; repeat (8) tick();
      ifb.async_in[1] = 1'b0; repeat (8) tick();
    end
    checks++; if (ifb.cnt_out !== 2'd3)    begin failures++; $display("FAIL sat_cnt got=%0d exp=3", ifb.cnt_out); end
    checks++; if (ifb.pending[1] !== 1'b1) begin failures++; $display("FAIL sat_pending got=%b exp=1", ifb.pending[1]); end
    ifb.async_in[1] = 1'b1;
    repeat (5) tick();
    ifb.clr[1] = 1'b1;
    tick();
    ifb.clr[1] = 1'b0;
    checks++; if (ifb.pulse_out[1] !== 1'b1) begin failures++; $display("FAIL clr_pulse got=%b exp=1", ifb.pulse_out[1]); end
    checks++; if (ifb.cnt_out !== 2'd1)      begin failures++; $display("FAIL clr_cnt got=%0d exp=1", ifb.cnt_out); end
    checks++; if (ifb.pending[1] !== 1'b1)   begin failures++; $display("FAIL clr_pending got=%b exp=1", ifb.pending[1]); end
    for (int s = NB; s < 8; s++) begin
      ifb.cnt_sel = 3'(s);
      #1;
      checks++; if (ifb.cnt_out !== 2'd0) begin failures++; $display("FAIL sel_range sel=%0d got=%0d exp=0", s, ifb.cnt_out); end
    end
  endtask

  task automatic test_ena();
    int bad;
    bad = 0;
    ifa.mode = 2'd0;
    ifa.async_in[2] = 1'b1;
    repeat (4) tick();
    ifa.ena = 1'b0;
    ifa.clr[3] = 1'b1; tick(); ifa.clr[3] = 1'b0;
    ifa.cnt_sel = 3'd3;
    checks++; if (ifa.pending[3] !== 1'b0) begin failures++; $display("FAIL ena_clr_pending got=%b exp=0", ifa.pending[3]); end
    checks++; if (ifa.cnt_out !== 8'd0)    begin failures++; $display("FAIL ena_clr_cnt got=%0d exp=0", ifa.cnt_out); end
    repeat (9) begin
      tick();
      if (ifa.level_out[2] !== 1'b0 || ifa.pulse_out[2] !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL ena_hold cycles_changed=%0d exp=0", bad); end
    ifa.ena = 1'b1;
    tick();
    checks++; if (ifa.level_out[2] !== 1'b0) begin failures++; $display("FAIL ena_resume_early got=%b exp=0", ifa.level_out[2]); end
    tick();
    checks++; if (ifa.level_out[2] !== 1'b1) begin failures++; $display("FAIL ena_resume_level got=%b exp=1", ifa.level_out[2]); end
    checks++; if (ifa.pulse_out[2] !== 1'b1) begin failures++; $display("FAIL ena_resume_pulse got=%b exp=1", ifa.pulse_out[2]); end
  endtask

  task automatic test_reset_mid();
    ifa.mode = 2'd0; ifa.ena = 1'b1; ifa.cnt_sel = 3'd2;
    ifa.async_in = '1;
    repeat (4) tick();
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (ifa.level_out !== '0) begin failures++; $display("FAIL rstmid_level got=%h exp=00", ifa.level_out); end
    checks++; if (ifa.pending !== '0)   begin failures++; $display("FAIL rstmid_pending got=%h exp=00", ifa.pending); end
    checks++; if (ifa.cnt_out !== '0)   begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", ifa.cnt_out); end
    repeat (2) tick();
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        checks++; if (ifa.level_out !== 8'h00) begin failures++; $display("FAIL rel_early got=%h exp=00", ifa.level_out); end
      end
      if (e == 6) begin
        checks++; if (ifa.level_out !== 8'hFF) begin failures++; $display("FAIL rel_level got=%h exp=ff", ifa.level_out); end
        checks++; if (ifa.pulse_out !== 8'hFF) begin failures++; $display("FAIL rel_pulse got=%h exp=ff", ifa.pulse_out); end
      end
      if (e == 7) begin
        checks++; if (ifa.pulse_out !== 8'h00) begin failures++; $display("FAIL rel_pulse_end got=%h exp=00", ifa.pulse_out); end
        checks++; if (ifa.pending !== 8'hFF)   begin failures++; $display("FAIL rel_pending got=%h exp=ff", ifa.pending); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) ifa.async_in[i] = ~ifa.async_in[i];
        ifa.clr[i] = ($urandom_range(0, 29) == 0);
      end
      ifa.ena = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) ifa.mode = 2'($urandom_range(0, 3));
      ifa.cnt_sel = 3'($urandom_range(0, 7));
      tick();
      checks++; if (ifa.level_out !== m_level) begin failures++; $display("FAIL rnd_level c=%0d got=%h exp=%h", c, ifa.level_out, m_level); end
      checks++; if (ifa.pulse_out !== m_pulse) begin failures++; $display("FAIL rnd_pulse c=%0d got=%h exp=%h", c, ifa.pulse_out, m_pulse); end
      checks++; if (ifa.pending !== m_pend)    begin failures++; $display("FAIL rnd_pending c=%0d got=%h exp=%h", c, ifa.pending, m_pend); end
      checks++; if (int'(ifa.cnt_out) != m_cnt[ifa.cnt_sel]) begin
        failures++; $display("FAIL rnd_cnt c=%0d sel=%0d got=%0d exp=%0d", c, ifa.cnt_sel, ifa.cnt_out, m_cnt[ifa.cnt_sel]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_modes();
    test_saturate();
    test_ena();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
